ahb3lite_dma_master: RTL and testbench
======================================

# ahb3lite_dma_master

Write-only AHB-Lite bus master that issues single and incrementing-burst write transfers on behalf of the DMA engine. Accepts one command at a time, pulls 32-bit words from a valid/ready source stream, and drives the AHB address and data phases toward the CPU/DMA memory slave. Inserts BUSY beats when the source stalls, obeys HREADY wait states, and aborts on an ERROR response.

## Interface
- No parameters; transfer size fixed at word (HSIZE = 3'b010), address step 4.
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high in DMA_IDLE only; command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  32  start address; bits [1:0] ignored (forced 0).
- cmd_burst  in  HBURST_Type  SINGLE, INCR, INCR4, INCR8, INCR16.
- cmd_len  in  8  INCR only: beat count = cmd_len+1 (1..256); ignored otherwise.
- src_data  in  32  write word.
- src_valid  in  1  src_data valid.
- src_ready  out  1  word consumed this cycle.
- HADDR  out  32  address-phase address.
- HTRANS  out  HTRANS_state  IDLE/BUSY/NONSEQ/SEQ.
- HBURST  out  HBURST_Type  latched cmd_burst.
- HSIZE  out  3  constant 3'b010.
- HWRITE  out  1  1 whenever HTRANS ≠ IDLE, else 0.
- HWDATA  out  32  data-phase word.
- HREADY  in  1  slave ready.
- HRESP  in  HRESP_state  OKAY/ERROR.
- done  out  1  one-cycle pulse: burst fully completed OKAY.
- err  out  1  one-cycle pulse: burst aborted on ERROR.

## Operation
- Beat count: SINGLE 1, INCR4 4, INCR8 8, INCR16 16, INCR cmd_len+1. Held in 9-bit remaining-address counter and 9-bit remaining-data counter.
- Address phase accepted at a rising edge with HREADY=1 and HTRANS ∈ {NONSEQ, SEQ}. At that edge: src_ready=1 (combinational: src_valid && HREADY && issuing), src_data captured into HWDATA register, HADDR += 4, address counter −1.
- Data phase completes at next edge with HREADY=1; data counter −1.
- States (dma_state_t): DMA_IDLE, DMA_ISSUE, DMA_DRAIN, DMA_ERR.
- DMA_IDLE: HTRANS=IDLE. On command accept: latch addr/burst/counts → DMA_ISSUE.
- DMA_ISSUE: first beat drives NONSEQ only when src_valid=1, else IDLE (no BUSY before first beat). Later beats: SEQ if src_valid, else BUSY with next HADDR held. HTRANS/HADDR never change while HREADY=0. Last beat accepted → DMA_DRAIN.
- DMA_DRAIN: HTRANS=IDLE; wait final data phase HREADY=1 → done pulse, DMA_IDLE.
- BUSY beats never complete a data phase and never pop the source.
- HRESP=ERROR with HREADY=0 (first error cycle): drive HTRANS=IDLE next cycle, discard remaining beats, → DMA_ERR. DMA_ERR: wait HREADY=1 → err pulse, DMA_IDLE. Words already popped are lost.
- 1 KB boundary crossing is caller's responsibility; no check.

## Timing
- Reset values: HTRANS=IDLE, HADDR=0, HWDATA=0, HBURST=SINGLE, HWRITE=0, done=0, err=0, cmd_ready=1, src_ready=0, state DMA_IDLE. Reset mid-burst drops transfer immediately, no done/err.
- Command accept → first NONSEQ: 1 cycle minimum (later if src_valid low).
- Zero-wait N-beat burst: NONSEQ + (N−1) SEQ on consecutive cycles, done pulses N+1 cycles after NONSEQ edge; cmd_ready high the cycle after done.
- HWDATA stable from address-accept edge until its data phase completes.
- src_ready never asserted in DMA_DRAIN, DMA_ERR, DMA_IDLE.

## Structure
- dma_state_t enum added to ahb3lite_pkg; reuse existing HTRANS_state, HBURST_Type, HRESP_state.
- Beat-length decode (burst → count) as package function burst_beats().
- Single module, no sub-modules.

## Test plan
- SINGLE, addr 0x1000, src 0xA5A5_0001, HREADY=1 → NONSEQ@0x1000, HWDATA=0xA5A5_0001 next cycle, done 2 cycles after NONSEQ.
- INCR4 @0x2000, src always valid → NONSEQ,SEQ,SEQ,SEQ at 0x2000/04/08/0C on consecutive cycles, 4 pops, done.
- INCR8 @0x3000, src_valid low 2 cycles after beat 3 → 2 BUSY beats at 0x300C held, then SEQ resumes, 8 pops total.
- INCR cmd_len=2, HREADY low 3 cycles during beat 2 data → HADDR/HTRANS/HWDATA frozen, 3 beats, done.
- INCR4, slave returns ERROR on beat 2 → HTRANS=IDLE next cycle, err pulse, no done, cmd_ready returns high.
- HRESETn low mid-INCR16 → all outputs at reset values asynchronously, new command after release runs normally.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// AHB3-Lite shared types for the DMA write master.
// Bus encodings, master FSM states and the burst length decode.
package ahb3lite_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } HTRANS_state;

   typedef enum logic [2:0] {
      SINGLE = 3'b000,
      INCR   = 3'b001,
      INCR4  = 3'b011,
      INCR8  = 3'b101,
      INCR16 = 3'b111
   } HBURST_Type;

   typedef enum logic {
      OKAY  = 1'b0,
      ERROR = 1'b1
   } HRESP_state;

   typedef enum logic [1:0] {
      DMA_IDLE,
      DMA_ISSUE,
      DMA_DRAIN,
      DMA_ERR
   } dma_state_t;

   localparam logic [2:0]  HSIZE_WORD = 3'b010;
   localparam logic [31:0] ADDR_STEP  = 32'd4;

   function automatic logic [8:0] burst_beats(
      input HBURST_Type b,
      input logic [7:0] len
   );
      case (b)
         INCR:    burst_beats = {1'b0, len} + 9'd1;
         INCR4:   burst_beats = 9'd4;
         INCR8:   burst_beats = 9'd8;
         INCR16:  burst_beats = 9'd16;
         default: burst_beats = 9'd1;
      endcase
   endfunction

endpackage

// File: rtl/ahb3lite_dma_master_if.sv
// AHB3-Lite write-master bus bundle.
// Master drives address/data phase, slave returns HREADY/HRESP.
interface ahb3lite_dma_master_if;
   import ahb3lite_pkg::*;

   logic [31:0] HADDR;
   HTRANS_state HTRANS;
   HBURST_Type  HBURST;
   logic [2:0]  HSIZE;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic        HREADY;
   HRESP_state  HRESP;

   modport master (
      output HADDR, HTRANS, HBURST,
      output HSIZE, HWRITE, HWDATA,
      input  HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HBURST,
      input  HSIZE, HWRITE, HWDATA,
      output HREADY, HRESP
   );

endinterface

// File: rtl/ahb3lite_dma_master.sv
// Write-only AHB3-Lite burst master for the DMA engine.
// Streams source words into SINGLE/INCR bursts, BUSY on stall.
module ahb3lite_dma_master
   import ahb3lite_pkg::*;
(
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  HBURST_Type  cmd_burst,
   input  logic [7:0]  cmd_len,
   input  logic [31:0] src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic        done,
   output logic        err,
   ahb3lite_dma_master_if.master ahb
);

   dma_state_t  state_q, state_d;
   HTRANS_state htrans, htr_q;
   HBURST_Type  hburst_q;
   logic [31:0] haddr_q;
   logic [31:0] hwdata_q;
   logic [8:0]  acnt_q;
   logic [8:0]  dcnt_q;
   logic        first_q;
   logic        dp_q;
   logic        hold_q;
   logic        done_q;
   logic        err_q;
   logic        issuing;
   logic        accept;
   logic        dp_done;
   logic        err_hit;

   always_comb begin
      htrans  = IDLE;
      state_d = state_q;
      // a transfer shown during a wait state is frozen until HREADY
      if (state_q == DMA_ISSUE) begin
         if (hold_q)
            htrans = htr_q;
         else if (first_q)
            htrans = src_valid ? NONSEQ : IDLE;
         else
            htrans = src_valid ? SEQ : BUSY;
      end
      issuing = (htrans == NONSEQ) || (htrans == SEQ);
      accept  = issuing && ahb.HREADY;
      dp_done = dp_q && ahb.HREADY;
      err_hit = dp_q && !ahb.HREADY
             && (ahb.HRESP == ERROR);
      unique case (state_q)
         DMA_IDLE:
            if (cmd_valid) state_d = DMA_ISSUE;
         DMA_ISSUE:
            if (err_hit)
               state_d = DMA_ERR;
            else if (accept && acnt_q == 9'd1)
               state_d = DMA_DRAIN;
         DMA_DRAIN:
            if (err_hit)
               state_d = DMA_ERR;
            else if (dp_done && dcnt_q == 9'd1)
               state_d = DMA_IDLE;
         DMA_ERR:
            if (ahb.HREADY) state_d = DMA_IDLE;
         default:
            state_d = DMA_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= DMA_IDLE;
         htr_q    <= IDLE;
         hburst_q <= SINGLE;
         haddr_q  <= 32'd0;
         hwdata_q <= 32'd0;
         acnt_q   <= 9'd0;
         dcnt_q   <= 9'd0;
         first_q  <= 1'b0;
         dp_q     <= 1'b0;
         hold_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         htr_q   <= htrans;
         hold_q  <= (state_q == DMA_ISSUE)
                 && (state_d == DMA_ISSUE)
                 && !ahb.HREADY;
         done_q  <= (state_q == DMA_DRAIN)
                 && (state_d == DMA_IDLE);
         err_q   <= (state_q == DMA_ERR)
                 && ahb.HREADY;
         if (state_q == DMA_IDLE && cmd_valid) begin
            haddr_q  <= cmd_addr & ~32'h3;
            hburst_q <= cmd_burst;
            acnt_q   <= burst_beats(cmd_burst, cmd_len);
            dcnt_q   <= burst_beats(cmd_burst, cmd_len);
            first_q  <= 1'b1;
         end
         if (accept) begin
            haddr_q <= haddr_q + ADDR_STEP;
            acnt_q  <= acnt_q - 9'd1;
            first_q <= 1'b0;
         end
         if (src_ready)
            hwdata_q <= src_data;
         if (err_hit)
            dp_q <= 1'b0;
         else if (ahb.HREADY)
            dp_q <= accept;
         if (dp_done)
            dcnt_q <= dcnt_q - 9'd1;
      end
   end

   assign cmd_ready  = (state_q == DMA_IDLE);
   assign src_ready  = src_valid && accept;
   assign done       = done_q;
   assign err        = err_q;
   assign ahb.HADDR  = haddr_q;
   assign ahb.HTRANS = htrans;
   assign ahb.HBURST = hburst_q;
   assign ahb.HSIZE  = HSIZE_WORD;
   assign ahb.HWRITE = (htrans != IDLE);
   assign ahb.HWDATA = hwdata_q;

endmodule

// File: tb/tb_ahb3lite_dma_master.sv
// Bench for ahb3lite_dma_master: random source/slave traffic
// scored against per-beat address, data and handshake rules.
module tb_ahb3lite_dma_master;
   import ahb3lite_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   HBURST_Type  cmd_burst;
   logic [7:0]  cmd_len;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic        done;
   logic        err;

   ahb3lite_dma_master_if ahb();

   ahb3lite_dma_master dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_burst (cmd_burst),
      .cmd_len   (cmd_len),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .done      (done),
      .err       (err),
      .ahb       (ahb)
   );

   always #5 HCLK = ~HCLK;

   int checks;
   int errors;

   bit          sv_cur;
   logic [31:0] sd_cur;
   int          stall_cnt;

   int cfg_vpct, cfg_rpct, cfg_err_beat;
   int cfg_stall_at, cfg_stall_len;
   int cfg_wait_beat, cfg_wait_len;
   int cfg_stop_after;
   bit cfg_timing;

   int          r_ns_cyc, r_done_cyc, r_busy, r_beats;
   logic [31:0] r_first;

   function automatic int nbeats(input HBURST_Type b, input logic [7:0] l);
      case (b)
         SINGLE:  return 1;
         INCR4:   return 4;
         INCR8:   return 8;
         INCR16:  return 16;
         default: return int'(l) + 1;
      endcase
   endfunction

   task automatic set_defaults();
      cfg_vpct       = 100;
      cfg_rpct       = 0;
      cfg_err_beat   = 9999;
      cfg_stall_at   = -1;
      cfg_stall_len  = 0;
      cfg_wait_beat  = -1;
      cfg_wait_len   = 0;
      cfg_stop_after = 0;
      cfg_timing     = 1'b0;
      stall_cnt      = 0;
   endtask

   // source keeps a word valid until it is popped
   task automatic drive_src();
      if (stall_cnt > 0)
         stall_cnt--;
      else if (!sv_cur && int'($urandom_range(99)) < cfg_vpct) begin
         sv_cur = 1'b1;
         sd_cur = $urandom;
      end
      src_valid = sv_cur;
      src_data  = sd_cur;
   endtask

   task automatic run_burst(input logic [31:0] a, input HBURST_Type b,
                            input logic [7:0] l);
      int n, k_acc, k_done, cyc, pend_idx, wcnt;
      bit pend, fin, tail, got_done, got_err, prev_wait, e1, e2, exp_sr;
      logic [31:0] base, prev_addr, prev_wd;
      logic [31:0] words[$];
      HTRANS_state prev_tr;
      n = nbeats(b, l);
      base = a & ~32'h3;
      k_acc = 0; k_done = 0; cyc = 0; pend_idx = 0; wcnt = 0;
      pend = 0; fin = 0; tail = 0; got_done = 0; got_err = 0;
      prev_wait = 0; e1 = 0; e2 = 0;
      prev_addr = '0; prev_wd = '0; prev_tr = IDLE;
      r_ns_cyc = -1; r_done_cyc = -1; r_busy = 0; r_beats = 0; r_first = '0;
      @(negedge HCLK);
      drive_src();
      ahb.HREADY = 1'b1;
      ahb.HRESP  = OKAY;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_burst = b;
      cmd_len   = l;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || src_ready !== 1'b0) begin
         errors++;
         $display("FAIL cmd_accept cmd_ready=%b src_ready=%b want 1/0",
                  cmd_ready, src_ready);
      end
      @(posedge HCLK);
      while (!fin && cyc < 3000) begin
         @(negedge HCLK);
         cmd_valid = 1'b0;
         drive_src();
         e2 = e1;
         e1 = 1'b0;
         if (e2) begin
            ahb.HREADY = 1'b1; ahb.HRESP = ERROR;
         end else if (pend && pend_idx == cfg_err_beat) begin
            ahb.HREADY = 1'b0; ahb.HRESP = ERROR; e1 = 1'b1;
         end else if (pend && pend_idx == cfg_wait_beat && wcnt < cfg_wait_len) begin
            ahb.HREADY = 1'b0; ahb.HRESP = OKAY; wcnt++;
         end else begin
            ahb.HREADY = (pend && int'($urandom_range(99)) < cfg_rpct) ? 1'b0 : 1'b1;
            ahb.HRESP  = OKAY;
         end
         #1;
         cyc++;
         checks++;
         if (ahb.HWRITE !== (ahb.HTRANS != IDLE)) begin
            errors++;
            $display("FAIL hwrite cyc %0d got %b with HTRANS %0d", cyc, ahb.HWRITE, ahb.HTRANS);
         end
         exp_sr = src_valid && ahb.HREADY && (ahb.HTRANS == NONSEQ || ahb.HTRANS == SEQ);
         checks++;
         if (src_ready !== exp_sr) begin
            errors++;
            $display("FAIL src_ready cyc %0d got %b want %b", cyc, src_ready, exp_sr);
         end
         if (e2) begin
            checks++;
            if (ahb.HTRANS !== IDLE) begin
               errors++;
               $display("FAIL err_idle got HTRANS %0d want IDLE", ahb.HTRANS);
            end
         end else if (prev_wait) begin
            checks++;
            if (ahb.HTRANS !== prev_tr || ahb.HADDR !== prev_addr || ahb.HWDATA !== prev_wd) begin
               errors++;
               $display("FAIL wait_hold got %0d/%h/%h want %0d/%h/%h", ahb.HTRANS,
                        ahb.HADDR, ahb.HWDATA, prev_tr, prev_addr, prev_wd);
            end
         end
         if (ahb.HTRANS == BUSY) begin
            r_busy++;
            checks++;
            if (k_acc == 0 || ahb.HADDR !== base + 32'(4 * k_acc)) begin
               errors++;
               $display("FAIL busy beat %0d addr %h want %h", k_acc, ahb.HADDR,
                        base + 32'(4 * k_acc));
            end
         end
         if (tail) begin
            checks++;
            if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
               errors++;
               $display("FAIL after_end cmd_ready=%b done=%b err=%b want 1/0/0",
                        cmd_ready, done, err);
            end
            fin = 1'b1;
         end else begin
            if (done === 1'b1) begin
               got_done = 1'b1; r_done_cyc = cyc; tail = 1'b1;
            end
            if (err === 1'b1) begin
               got_err = 1'b1; tail = 1'b1;
            end
         end
         if (pend && ahb.HREADY) begin
            if (ahb.HRESP == OKAY) begin
               checks++;
               if (ahb.HWDATA !== words[pend_idx]) begin
                  errors++;
                  $display("FAIL hwdata beat %0d got %h want %h", pend_idx,
                           ahb.HWDATA, words[pend_idx]);
               end
               k_done++;
            end
            pend = 1'b0;
         end
         if (ahb.HREADY && (ahb.HTRANS == NONSEQ || ahb.HTRANS == SEQ)) begin
            checks++;
            if (k_acc >= n || ahb.HADDR !== base + 32'(4 * k_acc) ||
                ahb.HTRANS !== (k_acc == 0 ? NONSEQ : SEQ)) begin
               errors++;
               $display("FAIL addr_beat %0d of %0d got %h/%0d want %h", k_acc, n,
                        ahb.HADDR, ahb.HTRANS, base + 32'(4 * k_acc));
            end
            words.push_back(src_data);
            if (src_ready) sv_cur = 1'b0;
            if (k_acc == 0) r_ns_cyc = cyc;
            if (k_acc + 1 == cfg_stall_at) stall_cnt = cfg_stall_len;
            pend = 1'b1;
            pend_idx = k_acc;
            k_acc++;
         end
         prev_wait = !ahb.HREADY && !e1;
         prev_tr   = ahb.HTRANS;
         prev_addr = ahb.HADDR;
         prev_wd   = ahb.HWDATA;
         if (cfg_stop_after > 0 && cyc >= cfg_stop_after) fin = 1'b1;
         @(posedge HCLK);
      end
      r_beats = k_acc;
      if (words.size() > 0) r_first = words[0];
      if (cfg_stop_after > 0) return;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL timeout burst %0d beats acc=%0d got done=%b err=%b", n, k_acc,
                  got_done, got_err);
      end
      if (cfg_err_beat < n) begin
         checks++;
         if (!got_err || got_done || k_acc != cfg_err_beat + 1) begin
            errors++;
            $display("FAIL err_burst err=%b done=%b beats=%0d want 1/0/%0d",
                     got_err, got_done, k_acc, cfg_err_beat + 1);
         end
      end else begin
         checks++;
         if (!got_done || got_err || k_acc != n || k_done != n) begin
            errors++;
            $display("FAIL burst_end done=%b err=%b acc=%0d data=%0d want 1/0/%0d/%0d",
                     got_done, got_err, k_acc, k_done, n, n);
         end
      end
      if (cfg_timing) begin
         checks++;
         if (r_ns_cyc != 1 || r_done_cyc - r_ns_cyc != n + 1) begin
            errors++;
            $display("FAIL timing nonseq@%0d done@%0d want 1 and %0d", r_ns_cyc,
                     r_done_cyc, n + 2);
         end
      end
   endtask

   task automatic check_reset_vals(input string tag);
      checks++;
      if (ahb.HTRANS !== IDLE || ahb.HADDR !== 32'd0 || ahb.HWDATA !== 32'd0 ||
          ahb.HBURST !== SINGLE || ahb.HWRITE !== 1'b0 || ahb.HSIZE !== 3'b010) begin
         errors++;
         $display("FAIL %s_bus got %0d/%h/%h/%0d/%b/%b want 0/0/0/0/0/010", tag,
                  ahb.HTRANS, ahb.HADDR, ahb.HWDATA, ahb.HBURST, ahb.HWRITE, ahb.HSIZE);
      end
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1 || src_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_ctl done=%b err=%b cmd_ready=%b src_ready=%b want 0/0/1/0",
                  tag, done, err, cmd_ready, src_ready);
      end
   endtask

   task automatic test_reset();
      HRESETn = 1'b0;
      sv_cur = 1'b1;
      sd_cur = 32'h1234_5678;
      src_valid = 1'b1;
      src_data = sd_cur;
      repeat (2) @(negedge HCLK);
      #1;
      check_reset_vals("reset");
      @(negedge HCLK);
      HRESETn = 1'b1;
      #1;
      check_reset_vals("release");
   endtask

   task automatic test_single();
      set_defaults();
      cfg_timing = 1'b1;
      sv_cur = 1'b1;
      sd_cur = 32'hA5A5_0001;
      run_burst(32'h0000_1000, SINGLE, 8'd0);
      checks++;
      if (r_first !== 32'hA5A5_0001 || r_beats != 1) begin
         errors++;
         $display("FAIL single word %h beats %0d want a5a50001/1", r_first, r_beats);
      end
   endtask

   task automatic test_incr4();
      set_defaults();
      cfg_timing = 1'b1;
      run_burst(32'h0000_2000, INCR4, 8'd0);
      checks++;
      if (r_beats != 4 || r_busy != 0) begin
         errors++;
         $display("FAIL incr4 beats %0d busy %0d want 4/0", r_beats, r_busy);
      end
   endtask

   task automatic test_incr8_busy();
      set_defaults();
      cfg_stall_at = 3;
      cfg_stall_len = 2;
      run_burst(32'h0000_3000, INCR8, 8'd0);
      checks++;
      if (r_beats != 8 || r_busy != 2) begin
         errors++;
         $display("FAIL incr8_busy beats %0d busy %0d want 8/2", r_beats, r_busy);
      end
   endtask

   task automatic test_incr_wait();
      set_defaults();
      cfg_wait_beat = 1;
      cfg_wait_len = 3;
      run_burst(32'h0000_4000, INCR, 8'd2);
      checks++;
      if (r_beats != 3 || r_done_cyc - r_ns_cyc != 7) begin
         errors++;
         $display("FAIL incr_wait beats %0d span %0d want 3/7", r_beats,
                  r_done_cyc - r_ns_cyc);
      end
   endtask

   task automatic test_error();
      set_defaults();
      cfg_err_beat = 1;
      run_burst(32'h0000_5000, INCR4, 8'd0);
      checks++;
      if (r_beats != 2) begin
         errors++;
         $display("FAIL error beats %0d want 2", r_beats);
      end
   endtask

   task automatic test_reset_mid();
      set_defaults();
      cfg_stop_after = 8;
      run_burst(32'h0000_6000, INCR16, 8'd0);
      #2;
      HRESETn = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      @(negedge HCLK);
      #1;
      check_reset_vals("mid_hold");
      HRESETn = 1'b1;
      set_defaults();
      cfg_vpct = 70;
      cfg_rpct = 20;
      run_burst(32'h0000_7000, INCR4, 8'd0);
   endtask

   task automatic test_random();
      HBURST_Type bl[5];
      HBURST_Type b;
      logic [7:0] l;
      int n;
      bl = '{SINGLE, INCR, INCR4, INCR8, INCR16};
      for (int i = 0; i < 25; i++) begin
         set_defaults();
         b = bl[$urandom_range(4)];
         l = 8'($urandom_range(15));
         n = nbeats(b, l);
         cfg_vpct = int'($urandom_range(100, 30));
         cfg_rpct = int'($urandom_range(50));
         if ($urandom_range(3) == 0)
            cfg_err_beat = int'($urandom_range(n - 1));
         run_burst($urandom, b, l);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      HRESETn = 1'b0;
      cmd_valid = 1'b0;
      cmd_addr = '0;
      cmd_burst = SINGLE;
      cmd_len = '0;
      src_valid = 1'b0;
      src_data = '0;
      sv_cur = 1'b0;
      sd_cur = '0;
      ahb.HREADY = 1'b1;
      ahb.HRESP = OKAY;
      set_defaults();
      test_reset();
      test_single();
      test_incr4();
      test_incr8_busy();
      test_incr_wait();
      test_error();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
